inst_encoder: RTL
=================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h0, the first instruction-memory byte address written.
REQ-002 SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have the port in_valid, input, 1 bit: the field bundle below is valid.
REQ-005 SHALL have the port in_ready, output, 1 bit: the encoder accepts the bundle this cycle.
REQ-006 SHALL have the port in_fmt, input, 3 bits: 0=R, 1=I, 2=S, 3=SB, 4=U, 5=UJ; 6 and 7 are illegal.
REQ-007 SHALL have the ports in_opcode, input, 7 bits; in_rd, in_rs1 and in_rs2, input, 5 bits each; in_funct3, input, 3 bits; in_funct7, input, 7 bits.
REQ-008 SHALL have the port in_imm, input, 64 bits: the sign-extended immediate in the same form that the team's immediate decoder produces.
REQ-009 SHALL have the port out_valid, output, 1 bit: out_inst and out_addr are valid.
REQ-010 SHALL have the port out_ready, input, 1 bit: the instruction-memory writer accepts the output.
REQ-011 SHALL have the port out_inst, output, 32 bits: the encoded instruction word.
REQ-012 SHALL have the port out_addr, output, 64 bits: the byte address for out_inst.
REQ-013 SHALL have the port err, output, 1 bit: a sticky encode error is present.
REQ-014 SHALL have the port err_code, output, 2 bits: 1=range, 2=misaligned, 3=illegal fmt.
REQ-015 SHALL have the port err_clear, input, 1 bit: a pulse that clears the error.
REQ-016 SHALL have the port count, output, 32 bits: the number of emitted instructions, wrapping.

Function
REQ-017 SHALL implement FSM states IDLE, FULL and ERR.
REQ-018 SHALL drive in_ready = (IDLE) or (FULL and out_ready); in ERR, in_ready SHALL be 0.
REQ-019 SHALL treat an input handshake as in_valid and in_ready, and an output handshake as out_valid and out_ready.
REQ-020 SHALL have latency 1: an accepted legal bundle appears on out_inst with out_valid=1 on the next cycle; sustained throughput SHALL be 1 per cycle.
REQ-021 SHALL drive out_valid=1 only in FULL; out_inst and out_addr SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 SHALL place opcode in [6:0] for every format.
REQ-023 R format SHALL encode rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
REQ-024 I format SHALL encode imm[11:0] in [31:20], plus rd, funct3 and rs1.
REQ-025 S format SHALL encode imm[11:5] in [31:25] and imm[4:0] in [11:7], plus funct3, rs1 and rs2.
REQ-026 SB format SHALL encode imm[12] in [31], imm[10:5] in [30:25], imm[4:1] in [11:8] and imm[11] in [7], plus funct3, rs1 and rs2.
REQ-027 U format SHALL encode imm[31:12] in [31:12], plus rd.
REQ-028 UJ format SHALL encode imm[19] in [31], imm[9:0] in [30:21], imm[10] in [20] and imm[18:11] in [19:12], plus rd; the UJ immediate SHALL be halfword units, matching the decoder.
REQ-029 Range rules: for I and S, in_imm[63:11] SHALL be all-equal; for SB, in_imm[63:12] SHALL be all-equal; for U, in_imm[63:31] SHALL be all-equal; for UJ, in_imm[63:19] SHALL be all-equal.
REQ-030 Alignment rules: for SB, in_imm[0] SHALL be 0; for U, in_imm[11:0] SHALL be 0.
REQ-031 Error priority SHALL be illegal fmt, then misaligned, then range.
REQ-032 An accepted errored bundle SHALL produce no output, SHALL enter ERR, and SHALL set err=1 and err_code.
REQ-033 If FULL with out_ready=1 when an errored bundle is accepted, the pending output SHALL complete its handshake in that same cycle.
REQ-034 In ERR, err_clear SHALL return the FSM to IDLE and clear err/err_code on the next edge; err_clear in other states SHALL have no effect.
REQ-035 On each output handshake, out_addr SHALL advance by 4 and count SHALL advance by 1, both wrapping modulo 2^64 and 2^32.
REQ-036 Simultaneous output handshake and legal input accept SHALL remain FULL, loading the new word at the advanced address.

Reset
REQ-037 When reset=1 at the rising edge, the block SHALL take state=IDLE, out_valid=0, out_inst=0, out_addr=BASE_ADDR, count=0, err=0 and err_code=0; reset SHALL dominate all inputs, including mid-handshake, and the pending word SHALL be discarded.

Structure
REQ-038 Format codes, error codes and opcode constants SHALL reside in a shared package, inst_pkg.
REQ-039 Field packing and checking SHALL be a combinational sub-module named imm_pack; the FSM, address counter and count SHALL reside in the top level.

Verification
REQ-040 An I-format with in_imm=64'hFFFF_FFFF_FFFF_FFFC, rd=5, rs1=6, funct3=0, opcode 0010011 -> out_inst=32'hFFC30293 one cycle later, out_addr=BASE_ADDR.
REQ-041 SB with in_imm=13 -> err=1, err_code=2, no out_valid; then err_clear -> IDLE and in_ready=1.
REQ-042 I-format with in_imm=2048 -> err_code=1; fmt=7 -> err_code=3.
REQ-043 Four back-to-back legal bundles with out_ready=1 -> four outputs on consecutive cycles, out_addr +0/+4/+8/+12, count=4.
REQ-044 out_ready=0 for 3 cycles while FULL -> out_inst stable and in_ready=0, then drained.
REQ-045 Round trip: random legal bundles fed into the team's immediate decoder -> reproduced in_imm for all formats; reset asserted while FULL -> out_valid=0 and out_addr=BASE_ADDR next cycle.

Source files
------------

// File: rtl/inst_pkg.sv
// rtl/inst_pkg.sv - shared encoder constants, format/error codes, FSM states
// Contents:
//   FMT_*        3-bit instruction format codes (6 and 7 are illegal)
//   err_code_e   encode error codes carried on err_code
//   enc_state_e  encoder FSM states
//   OPC_*        base opcode constants
//   fits_signed  true when v[63:lsb] are all equal
package inst_pkg;

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_SB = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_UJ = 3'd5;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_RANGE    = 2'd1,
        ERR_MISALIGN = 2'd2,
        ERR_FMT      = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FULL = 2'd1,
        ST_ERR  = 2'd2
    } enc_state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // The value survives truncation to lsb+1 bits iff an arithmetic shift
    // by lsb leaves nothing but copies of the sign bit.
    function automatic logic fits_signed(input logic [63:0] v, input int unsigned lsb);
        logic [63:0] s;
        s = 64'($signed(v) >>> lsb);
        return (s == 64'h0) || (s == {64{1'b1}});
    endfunction

endpackage

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - combinational field packer and immediate checker
// Ports:
//   fmt       in   instruction format code
//   opcode, rd, rs1, rs2, funct3, funct7   in   instruction fields
//   imm       in   sign-extended immediate (UJ in halfword units)
//   inst      out  packed 32-bit instruction word
//   err_code  out  ERR_NONE when legal, else highest-priority error
module imm_pack
    import inst_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [63:0] imm,
    output logic [31:0] inst,
    output logic [1:0]  err_code
);

    // Alignment is tested before range so misaligned wins when both fail.
    always_comb begin
        inst     = 32'h0;
        err_code = ERR_NONE;
        case (fmt)
            FMT_R: begin
                inst = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            FMT_I: begin
                inst = {imm[11:0], rs1, funct3, rd, opcode};
                if (!fits_signed(imm, 11)) err_code = ERR_RANGE;
            end
            FMT_S: begin
                inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                if (!fits_signed(imm, 11)) err_code = ERR_RANGE;
            end
            FMT_SB: begin
                inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                if (imm[0])                   err_code = ERR_MISALIGN;
                else if (!fits_signed(imm, 12)) err_code = ERR_RANGE;
            end
            FMT_U: begin
                inst = {imm[31:12], rd, opcode};
                if (imm[11:0] != 12'h0)       err_code = ERR_MISALIGN;
                else if (!fits_signed(imm, 31)) err_code = ERR_RANGE;
            end
            FMT_UJ: begin
                // imm already counts halfwords, so imm[0] is byte offset bit 1.
                inst = {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode};
                if (!fits_signed(imm, 19)) err_code = ERR_RANGE;
            end
            default: begin
                err_code = ERR_FMT;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - instruction encoder with one-entry output register
// Parameters:
//   BASE_ADDR  first instruction-memory byte address written
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          field bundle handshake
//   in_fmt .. in_imm           field bundle
//   out_valid/out_ready        encoded word handshake
//   out_inst, out_addr         encoded word and its byte address
//   err, err_code, err_clear   sticky encode error and its clear pulse
//   count                      emitted instruction count (wraps)
module inst_encoder
    import inst_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [63:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_addr,
    output logic        err,
    output logic [1:0]  err_code,
    input  logic        err_clear,
    output logic [31:0] count
);

    enc_state_e  state;
    logic [31:0] pack_inst;
    logic [1:0]  pack_err;
    logic        in_fire;
    logic        out_fire;

    imm_pack u_imm_pack (
        .fmt      (in_fmt),
        .opcode   (in_opcode),
        .rd       (in_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .funct3   (in_funct3),
        .funct7   (in_funct7),
        .imm      (in_imm),
        .inst     (pack_inst),
        .err_code (pack_err)
    );

    // A full register can take a new bundle only when it is draining now.
    assign in_ready = (state == ST_IDLE) || ((state == ST_FULL) && out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_inst  <= 32'h0;
            out_addr  <= BASE_ADDR;
            count     <= 32'h0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            // out_addr always points at the slot of the word held or next loaded,
            // so a word accepted alongside a drain lands at the advanced address.
            if (out_fire) begin
                out_addr <= out_addr + 64'd4;
                count    <= count + 32'd1;
            end
            case (state)
                ST_IDLE, ST_FULL: begin
                    if (in_fire) begin
                        if (pack_err != ERR_NONE) begin
                            state     <= ST_ERR;
                            out_valid <= 1'b0;
                            err       <= 1'b1;
                            err_code  <= pack_err;
                        end else begin
                            state     <= ST_FULL;
                            out_valid <= 1'b1;
                            out_inst  <= pack_inst;
                        end
                    end else if (out_fire) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_ERR: begin
                    if (err_clear) begin
                        state    <= ST_IDLE;
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
